// File: rtl/fp16_sgn_pipe_if.sv
// Request/result handshake bundle for fp16_sgn_pipe.
// master = issuer/consumer side, slave = the sign unit.
interface fp16_sgn_pipe_if #(
  parameter int unsigned TAG_W = 4
);
  logic             i_valid;
  logic             i_ready;
  logic [2:0]       op;
  logic [15:0]      a;
  logic [15:0]      b;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             o_ready;
  logic [15:0]      o;
  logic [TAG_W-1:0] o_tag;
  logic             nv;

  modport master (
    output i_valid, op, a, b, i_tag, o_ready,
    input  i_ready, o_valid, o, o_tag, nv
  );

  modport slave (
    input  i_valid, op, a, b, i_tag, o_ready,
    output i_ready, o_valid, o, o_tag, nv
  );
endinterface

// File: rtl/fp16_sgn_pipe.sv
// Two-stage FP16 sign unit (SGN/ABS/NEG/copysign) with tagged valid/ready flow.
// Define FP16_SGN_NAN_EN for IEEE NaN handling in SGN (qNaN result, nv on sNaN).
module fp16_sgn_pipe #(
  parameter int unsigned TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  fp16_sgn_pipe_if.slave bus
);
  typedef enum logic [2:0] {
    OP_SGN   = 3'b000,
    OP_ABS   = 3'b001,
    OP_NEG   = 3'b010,
    OP_CPYS  = 3'b011,
    OP_CPYSN = 3'b100,
    OP_CPYSX = 3'b101,
    OP_PASS6 = 3'b110,
    OP_PASS7 = 3'b111
  } op_e;

  logic             s1_v, s2_v;
  logic             s1_adv, s2_adv;
  op_e              s1_op;
  logic [15:0]      s1_a;
  logic             s1_bs;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_zero;
  logic [15:0]      s2_o;
  logic [TAG_W-1:0] s2_tag;
  logic [15:0]      res;
`ifdef FP16_SGN_NAN_EN
  logic             s1_nan, s1_snan;
  logic             s2_nv;
  logic             res_nv;
`endif

  assign s2_adv      = !s2_v || bus.o_ready;
  assign s1_adv      = !s1_v || s2_adv;
  assign bus.i_ready = s1_adv;
  assign bus.o_valid = s2_v;
  assign bus.o       = s2_o;
  assign bus.o_tag   = s2_tag;
`ifdef FP16_SGN_NAN_EN
  assign bus.nv      = s2_nv;
`else
  assign bus.nv      = 1'b0;
`endif

  // Stage-1 payload needs no reset: it is only consumed while s1_v is set.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.i_valid) begin
      s1_op   <= op_e'(bus.op);
      s1_a    <= bus.a;
      s1_bs   <= bus.b[15];
      s1_tag  <= bus.i_tag;
      s1_zero <= (bus.a[14:0] == '0);
`ifdef FP16_SGN_NAN_EN
      s1_nan  <= (bus.a[14:10] == 5'h1F) && (bus.a[9:0] != '0);
      s1_snan <= (bus.a[14:10] == 5'h1F) && (bus.a[9:0] != '0) && !bus.a[9];
`endif
    end
  end

  always_comb begin
    res = s1_a;
`ifdef FP16_SGN_NAN_EN
    res_nv = 1'b0;
`endif
    case (s1_op)
      OP_SGN: begin
        if (s1_zero)
          res = '0;
        else
          res = s1_a[15] ? 16'hBC00 : 16'h3C00;
`ifdef FP16_SGN_NAN_EN
        if (s1_nan) res = 16'h7E00;
        res_nv = s1_snan;
`endif
      end
      OP_ABS:   res = {1'b0, s1_a[14:0]};
      OP_NEG:   res = {~s1_a[15], s1_a[14:0]};
      OP_CPYS:  res = {s1_bs, s1_a[14:0]};
      OP_CPYSN: res = {~s1_bs, s1_a[14:0]};
      OP_CPYSX: res = {s1_a[15] ^ s1_bs, s1_a[14:0]};
      default:  res = s1_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s2_o   <= '0;
      s2_tag <= '0;
`ifdef FP16_SGN_NAN_EN
      s2_nv  <= 1'b0;
`endif
    end else begin
      if (s1_adv) s1_v <= bus.i_valid;
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_o   <= res;
          s2_tag <= s1_tag;
`ifdef FP16_SGN_NAN_EN
          s2_nv  <= res_nv;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_fp16_sgn_pipe.sv
// Directed self-checking bench for fp16_sgn_pipe; honours FP16_SGN_NAN_EN
// to select the expected NaN behaviour of SGN.
module tb_fp16_sgn_pipe;
  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fp16_sgn_pipe_if #(.TAG_W(TAG_W)) bus ();

  fp16_sgn_pipe #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [TAG_W-1:0] tag);
    bus.i_valid = 1'b1;
    bus.op      = op;
    bus.a       = a;
    bus.b       = b;
    bus.i_tag   = tag;
  endtask

  // Issue one request into an empty pipe and check its result two edges later.
  task automatic single_op(input string name, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [TAG_W-1:0] tag,
                           input logic [15:0] exp_o, input logic exp_nv);
    bus.o_ready = 1'b1;
    drive(op, a, b, tag);
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL %s_i_ready got=%b exp=1", name, bus.i_ready);
    end
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL %s_early_valid got=%b exp=0", name, bus.o_valid);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o !== exp_o || bus.o_tag !== tag || bus.nv !== exp_nv) begin
      errors++;
      $display("FAIL %s got v=%b o=%h tag=%h nv=%b exp v=1 o=%h tag=%h nv=%b",
               name, bus.o_valid, bus.o, bus.o_tag, bus.nv, exp_o, tag, exp_nv);
    end
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.i_tag = '0;
    bus.o_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o !== 16'h0000 || bus.o_tag !== '0 || bus.nv !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b o=%h tag=%h nv=%b exp v=0 o=0000 tag=0 nv=0",
               bus.o_valid, bus.o, bus.o_tag, bus.nv);
    end
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL reset_i_ready got=%b exp=1", bus.i_ready);
    end
  endtask

  task automatic test_sgn_zero();
    single_op("sgn_neg_zero", 3'b000, 16'h8000, 16'h0000, 4'h5, 16'h0000, 1'b0);
    single_op("sgn_pos_zero", 3'b000, 16'h0000, 16'h0000, 4'h6, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3] = '{16'h0001, 16'hFC00, 16'h4500};
    logic [15:0] ve [3] = '{16'h3C00, 16'hBC00, 16'h3C00};
    bus.o_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(3'b000, va[i], 16'h0000, TAG_W'(i + 1));
      else bus.i_valid = 1'b0;
      tick();
      if (i >= 1 && i <= 3) begin
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o !== ve[i-1] || bus.o_tag !== TAG_W'(i)) begin
          errors++;
          $display("FAIL b2b_%0d got v=%b o=%h tag=%h exp v=1 o=%h tag=%h",
                   i - 1, bus.o_valid, bus.o, bus.o_tag, ve[i-1], TAG_W'(i));
        end
      end
    end
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty got v=%b exp=0", bus.o_valid);
    end
  endtask

  task automatic test_ops();
    single_op("cpys",  3'b011, 16'h4200, 16'h8000, 4'h1, 16'hC200, 1'b0);
    single_op("cpysx", 3'b101, 16'hC200, 16'h8000, 4'h2, 16'h4200, 1'b0);
    single_op("neg",   3'b010, 16'h7E00, 16'h0000, 4'h3, 16'hFE00, 1'b0);
    single_op("abs",   3'b001, 16'hC200, 16'h0000, 4'h4, 16'h4200, 1'b0);
    single_op("cpysn", 3'b100, 16'h4200, 16'h0000, 4'h7, 16'hC200, 1'b0);
    single_op("pass6", 3'b110, 16'hB234, 16'hFFFF, 4'h8, 16'hB234, 1'b0);
    single_op("pass7", 3'b111, 16'h7D00, 16'h8000, 4'hA, 16'h7D00, 1'b0);
    single_op("sgn_subn", 3'b000, 16'h8001, 16'h0000, 4'hB, 16'hBC00, 1'b0);
    single_op("abs_snan", 3'b001, 16'hFD00, 16'h0000, 4'hC, 16'h7D00, 1'b0);
  endtask

  task automatic test_stall();
    logic [15:0]      sa [3] = '{16'h1101, 16'h1102, 16'h1103};
    logic [TAG_W-1:0] rtag [3];
    logic [15:0]      rdat [3];
    int idx = 0;
    int got = 0;
    logic acc;
    tick();
    bus.o_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) drive(3'b010, sa[idx], 16'h0000, TAG_W'(idx + 1));
      acc = bus.i_valid && bus.i_ready;
      tick();
      if (acc) idx++;
      if (c >= 1) begin
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o !== 16'h9101 || bus.o_tag !== 4'h1) begin
          errors++;
          $display("FAIL stall_hold_%0d got v=%b o=%h tag=%h exp v=1 o=9101 tag=1",
                   c, bus.o_valid, bus.o, bus.o_tag);
        end
      end
    end
    checks++;
    if (idx !== 2 || bus.i_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_accepts got accepts=%0d i_ready=%b exp accepts=2 i_ready=0", idx, bus.i_ready);
    end
    bus.o_ready = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_i_ready got=%b exp=1", bus.i_ready);
    end
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (idx < 3) drive(3'b010, sa[idx], 16'h0000, TAG_W'(idx + 1));
      else bus.i_valid = 1'b0;
      acc = bus.i_valid && bus.i_ready;
      if (bus.o_valid) begin
        rtag[got] = bus.o_tag;
        rdat[got] = bus.o;
        got++;
      end
      tick();
      if (acc) idx++;
    end
    bus.i_valid = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++; $display("FAIL stall_drain_count got=%0d exp=3", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (rtag[i] !== TAG_W'(i + 1) || rdat[i] !== (sa[i] ^ 16'h8000)) begin
        errors++;
        $display("FAIL stall_drain_%0d got tag=%h o=%h exp tag=%h o=%h",
                 i, rtag[i], rdat[i], TAG_W'(i + 1), sa[i] ^ 16'h8000);
      end
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    bus.o_ready = 1'b0;
    tick();
    drive(3'b001, 16'hC000, 16'h0000, 4'hD);
    tick();
    drive(3'b001, 16'hC100, 16'h0000, 4'hE);
    tick();
    bus.i_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid got=%b exp=0", bus.o_valid);
    end
    rst = 1'b0;
    bus.o_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.o_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++; $display("FAIL rst_mid_stale got=%0d stale cycles exp=0", stale);
    end
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_i_ready got=%b exp=1", bus.i_ready);
    end
  endtask

  task automatic test_nan();
`ifdef FP16_SGN_NAN_EN
    single_op("sgn_snan", 3'b000, 16'h7D00, 16'h0000, 4'h9, 16'h7E00, 1'b1);
    single_op("sgn_qnan_neg", 3'b000, 16'hFE00, 16'h0000, 4'hF, 16'h7E00, 1'b0);
`else
    single_op("sgn_snan", 3'b000, 16'h7D00, 16'h0000, 4'h9, 16'h3C00, 1'b0);
    single_op("sgn_qnan_neg", 3'b000, 16'hFE00, 16'h0000, 4'hF, 16'hBC00, 1'b0);
`endif
    single_op("neg_snan", 3'b010, 16'h7D00, 16'h0000, 4'h2, 16'hFD00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sgn_zero();
    test_back_to_back();
    test_ops();
    test_stall();
    test_reset_mid();
    test_nan();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
